serial_alu_seq: RTL and testbench

Bit-serial N-bit sequencer that drives the team's 1-bit ALU slice, one operand bit per clock, LSB first. It chains the carry between bits by choosing each cycle's slice mode/opcode from its registered carry. It reassembles the result word and reports carry-out. It sits between a word-level command source (start/busy/done handshake) and a single combinational 1-bit slice.

---
 rtl/serial_alu_seq_if.sv | 25 ++
 rtl/serial_alu_seq.sv | 117 +++++++++++
 tb/tb_serial_alu_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/serial_alu_seq_if.sv
// Word-level command handshake between a command source and serial_alu_seq.
// The master issues start/cmd/operands; the slave returns busy/done/result.
interface serial_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             co;
  logic             err;

  modport master (
    output start, cmd, a, b,
    input  busy, done, y, co, err
  );

  modport slave (
    input  start, cmd, a, b,
    output busy, done, y, co, err
  );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer driving a combinational 1-bit ALU slice, LSB first,
// chaining the carry through the slice code and reassembling the result word.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_alu_seq_if.slave   bus,
  output logic [1:0]        slice_mode,
  output logic [1:0]        slice_opcode,
  output logic              slice_ain,
  output logic              slice_bin,
  input  logic              slice_result,
  input  logic              slice_cout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [2:0] {
    C_PASS = 3'd0, C_NOT = 3'd1, C_XOR = 3'd2, C_XNOR = 3'd3,
    C_ADD  = 3'd4, C_INC = 3'd5
  } cmd_e;

  state_e           state;
  cmd_e             cmd_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             arith;
  logic             cmd_ok;

  assign arith  = (cmd_q == C_ADD) || (cmd_q == C_INC);
  assign cmd_ok = (bus.cmd <= 3'd5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cmd_q    <= C_PASS;
      a_q      <= '0;
      b_q      <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.y    <= '0;
      bus.co   <= 1'b0;
      bus.err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.done <= 1'b0;
          bus.err  <= 1'b0;
          if (bus.start) begin
            bus.y  <= '0;
            bus.co <= 1'b0;
            if (cmd_ok) begin
              cmd_q    <= cmd_e'(bus.cmd);
              a_q      <= bus.a;
              b_q      <= bus.b;
              idx      <= '0;
              carry    <= (bus.cmd == C_INC);
              bus.busy <= 1'b1;
              state    <= S_RUN;
            end else begin
              bus.err  <= 1'b1;
              bus.done <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_RUN: begin
          bus.y <= {slice_result, bus.y[WIDTH-1:1]};
          idx   <= idx + IW'(1);
          // Logic ops never sample slice_cout, so an X there cannot reach carry/co.
          if (arith) carry <= slice_cout;
          if (idx == LAST) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.err  <= 1'b0;
            bus.co   <= arith ? slice_cout : 1'b0;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          bus.err  <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    slice_mode   = 2'b00;
    slice_opcode = 2'b00;
    slice_ain    = 1'b0;
    slice_bin    = 1'b0;
    if (state == S_RUN) begin
      slice_ain = a_q[idx];
      slice_bin = b_q[idx];
      case (cmd_q)
        C_PASS:  {slice_mode, slice_opcode} = 4'b0000;
        C_NOT:   {slice_mode, slice_opcode} = 4'b0001;
        C_XOR:   {slice_mode, slice_opcode} = 4'b0010;
        C_XNOR:  {slice_mode, slice_opcode} = 4'b0011;
        C_ADD:   {slice_mode, slice_opcode} = carry ? 4'b1010 : 4'b0110;
        C_INC:   {slice_mode, slice_opcode} = carry ? 4'b1000 : 4'b0100;
        default: {slice_mode, slice_opcode} = 4'b0000;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq with a behavioural 1-bit slice model.
module tb_serial_alu_seq;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] slice_mode, slice_opcode;
  logic       slice_ain, slice_bin;
  logic       slice_result, slice_cout;

  int n_assert = 0;
  int n_fail   = 0;

  serial_alu_seq_if #(.WIDTH(W)) bus ();

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .slice_mode   (slice_mode),
    .slice_opcode (slice_opcode),
    .slice_ain    (slice_ain),
    .slice_bin    (slice_bin),
    .slice_result (slice_result),
    .slice_cout   (slice_cout)
  );

  always #5 clk = ~clk;

  always_comb begin
    slice_result = 1'bx;
    slice_cout   = 1'bx;
    case ({slice_mode, slice_opcode})
      4'b0000: slice_result = slice_ain;
      4'b0001: slice_result = ~slice_ain;
      4'b0010: slice_result = slice_ain ^ slice_bin;
      4'b0011: slice_result = ~(slice_ain ^ slice_bin);
      4'b0100: {slice_cout, slice_result} = {1'b0, slice_ain};
      4'b0110: {slice_cout, slice_result} = 2'(slice_ain) + 2'(slice_bin);
      4'b1000: {slice_cout, slice_result} = 2'(slice_ain) + 2'd1;
      4'b1010: {slice_cout, slice_result} = 2'(slice_ain) + 2'(slice_bin) + 2'd1;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and check the whole RUN/DONE window; operands are
  // scrambled after acceptance to prove they were latched.
  task automatic run_op(input string tag, input logic [2:0] c, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] ey, input logic eco);
    bus.cmd = c; bus.a = av; bus.b = bv; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.a = ~av; bus.b = ~bv;
    for (int unsigned i = 0; i < W; i++) begin
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      chk({tag, " done_early"}, 32'(bus.done), 32'd0);
      chk({tag, " ain"}, 32'(slice_ain), 32'(av[i]));
      step();
    end
    chk({tag, " done"}, 32'(bus.done), 32'd1);
    chk({tag, " busy_off"}, 32'(bus.busy), 32'd0);
    chk({tag, " y"}, 32'(bus.y), 32'(ey));
    chk({tag, " co"}, 32'(bus.co), 32'(eco));
    chk({tag, " err"}, 32'(bus.err), 32'd0);
    step();
    chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, " y_hold"}, 32'(bus.y), 32'(ey));
  endtask

  initial begin
    bus.start = 1'b0; bus.cmd = 3'd0; bus.a = '0; bus.b = '0;
    #12;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst y", 32'(bus.y), 32'd0);
    chk("rst co", 32'(bus.co), 32'd0);
    chk("rst err", 32'(bus.err), 32'd0);
    chk("rst slice", 32'({slice_mode, slice_opcode, slice_ain, slice_bin}), 32'd0);
    rst_n = 1'b1;
    step();

    run_op("add5a3c", 3'b100, 8'h5A, 8'h3C, 8'h96, 1'b0);
    run_op("addff01", 3'b100, 8'hFF, 8'h01, 8'h00, 1'b1);
    run_op("incff",   3'b101, 8'hFF, 8'h00, 8'h00, 1'b1);
    run_op("inc7f",   3'b101, 8'h7F, 8'h00, 8'h80, 1'b0);
    run_op("xor",     3'b010, 8'hA5, 8'h0F, 8'hAA, 1'b0);
    run_op("not",     3'b001, 8'h3C, 8'h00, 8'hC3, 1'b0);
    run_op("xnor",    3'b011, 8'hF0, 8'hFF, 8'hF0, 1'b0);
    run_op("pass",    3'b000, 8'h69, 8'h00, 8'h69, 1'b0);
    chk("idle slice", 32'({slice_mode, slice_opcode, slice_ain, slice_bin}), 32'd0);

    // Restarts at edges 3 and 9 must be ignored.
    bus.cmd = 3'b100; bus.a = 8'h5A; bus.b = 8'h3C; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.a = 8'h11; bus.b = 8'h22;
    for (int unsigned c = 1; c <= 8; c++) begin
      bus.start = (c == 3);
      chk("restart busy", 32'(bus.busy), 32'd1);
      step();
    end
    bus.start = 1'b1;
    chk("restart done", 32'(bus.done), 32'd1);
    chk("restart y", 32'(bus.y), 32'h96);
    step();
    bus.start = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      chk("restart idle busy", 32'(bus.busy), 32'd0);
      chk("restart idle done", 32'(bus.done), 32'd0);
      chk("restart idle y", 32'(bus.y), 32'h96);
      step();
    end

    // Invalid command.
    bus.cmd = 3'b110; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("inv done", 32'(bus.done), 32'd1);
    chk("inv err", 32'(bus.err), 32'd1);
    chk("inv y", 32'(bus.y), 32'd0);
    chk("inv co", 32'(bus.co), 32'd0);
    chk("inv busy", 32'(bus.busy), 32'd0);
    step();
    chk("inv done_pulse", 32'(bus.done), 32'd0);
    run_op("post_inv", 3'b100, 8'h10, 8'h20, 8'h30, 1'b0);

    // Asynchronous reset in cycle 4 of an ADD.
    bus.cmd = 3'b100; bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(bus.busy), 32'd0);
    chk("arst done", 32'(bus.done), 32'd0);
    chk("arst y", 32'(bus.y), 32'd0);
    chk("arst co", 32'(bus.co), 32'd0);
    chk("arst slice", 32'({slice_mode, slice_opcode, slice_ain, slice_bin}), 32'd0);
    step();
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 10; c++) begin
      chk("arst no_done", 32'(bus.done), 32'd0);
      step();
    end
    run_op("post_rst", 3'b100, 8'h01, 8'h01, 8'h02, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
